// File: rtl/rv_wb_pkg.sv
// Shared types and helpers for the register-file writeback path.
`timescale 1ns/1ps
package rv_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WB_XLEN    = 32;

    // Writeback request at the default datapath width.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_XLEN-1:0]    data;
    } wb_req_t;

    function automatic logic [31:0] onehot32(input logic [REG_ADDR_W-1:0] idx);
        logic [31:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a writeback source: valid/ready in, grant out-drains.
`timescale 1ns/1ps
module wb_hold_slot
    import rv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_data,
    input  logic                  grant,
    output logic                  full,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       data
);

    logic                  full_q, full_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       data_q, data_d;

    // A granted slot drains this edge, so it may reload in the same edge.
    assign in_ready = !full_q || grant;

    always_comb begin
        full_d = full_q;
        rd_d   = rd_q;
        data_d = data_q;
        if (grant) begin
            full_d = 1'b0;
        end
        // Writes to x0 are acknowledged but never stored.
        if (in_valid && in_ready && (in_rd != '0)) begin
            full_d = 1'b1;
            rd_d   = in_rd;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign rd   = rd_q;
    assign data = data_q;

endmodule

// File: rtl/rf_writeback.sv
// Writeback arbiter: merges ALU and LSU results onto the register file's single write port.
`timescale 1ns/1ps
module rf_writeback
    import rv_wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  rd_we,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_data,
    output logic [31:0]           pending
);

    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic                  alu_full, lsu_full;
    logic                  alu_grant, lsu_grant;
    logic [REG_ADDR_W-1:0] alu_slot_rd, lsu_slot_rd;
    logic [XLEN-1:0]       alu_slot_data, lsu_slot_data;

    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                  rd_we_q, rd_we_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]       rd_data_q, rd_data_d;

    wb_hold_slot #(.XLEN(XLEN)) u_alu_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (alu_valid),
        .in_ready (alu_ready),
        .in_rd    (alu_rd),
        .in_data  (alu_data),
        .grant    (alu_grant),
        .full     (alu_full),
        .rd       (alu_slot_rd),
        .data     (alu_slot_data)
    );

    wb_hold_slot #(.XLEN(XLEN)) u_lsu_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (lsu_valid),
        .in_ready (lsu_ready),
        .in_rd    (lsu_rd),
        .in_data  (lsu_data),
        .grant    (lsu_grant),
        .full     (lsu_full),
        .rd       (lsu_slot_rd),
        .data     (lsu_slot_data)
    );

    // Loads normally win; a starved ALU is forced through after MAX_WAIT losses.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (alu_full && lsu_full) begin
            if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
                alu_grant = 1'b1;
            end else begin
                lsu_grant = 1'b1;
            end
        end else begin
            alu_grant = alu_full;
            lsu_grant = lsu_full;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (alu_full && !alu_grant) begin
            wait_cnt_d = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? wait_cnt_q
                                                           : wait_cnt_q + WAIT_W'(1);
        end
    end

    always_comb begin
        rd_we_d   = alu_grant || lsu_grant;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (lsu_grant) begin
            rd_addr_d = lsu_slot_rd;
            rd_data_d = lsu_slot_data;
        end else if (alu_grant) begin
            rd_addr_d = alu_slot_rd;
            rd_data_d = alu_slot_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            rd_we_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_we_q    <= rd_we_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Destinations still in flight: held in a slot or on the write port this cycle.
    always_comb begin
        pending = '0;
        if (alu_full) begin
            pending = pending | onehot32(alu_slot_rd);
        end
        if (lsu_full) begin
            pending = pending | onehot32(lsu_slot_rd);
        end
        if (rd_we_q) begin
            pending = pending | onehot32(rd_addr_q);
        end
        pending[0] = 1'b0;
    end

    assign rd_we   = rd_we_q;
    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback with an in-order scoreboard on the write port.
`timescale 1ns/1ps
module tb_rf_writeback;
   import rv_wb_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
   logic [4:0]  alu_rd, lsu_rd, rd_addr;
   logic [31:0] alu_data, lsu_data, rd_data, pending;
   logic        rd_we;

   int testsRun = 0;
   int testsFailed = 0;
   wb_req_t expQ[$];
   wb_req_t monExp;

   int aluSeq, lsuSeq;
   logic aluTake, lsuTake;
   logic aluRdyExp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic lsuRdyExp [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

   rf_writeback #(.XLEN(32), .MAX_WAIT(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .rd_we     (rd_we),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .pending   (pending)
   );

   // Free-running 10ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
      alu_valid = av;
      alu_rd    = ard;
      alu_data  = adat;
      lsu_valid = lv;
      lsu_rd    = lrd;
      lsu_data  = ldat;
   endtask

   task automatic expectWrite(input logic [4:0] rd, input logic [31:0] data);
      wb_req_t r;
      r.rd   = rd;
      r.data = data;
      expQ.push_back(r);
   endtask

   task automatic drainAndCheck(input int cycles, input string tag);
      for (int c = 0; c < cycles; c++) @(negedge clk);
      checkOutput(tag, 64'(expQ.size()), 64'd0);
   endtask

   // Every write on the port must match the next expected entry, in order.
   always @(negedge clk) begin
      if (rd_we === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_write", 64'(rd_we), 64'd0);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("write_port", {27'd0, rd_addr, rd_data}, {27'd0, monExp.rd, monExp.data});
         end
      end
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run did not complete, tests=%0d", testsRun);
      $fatal(1, "[TB] watchdog timeout");
   end

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

      // Reset state.
      @(negedge clk);
      checkOutput("reset_rd_we", 64'(rd_we), 64'd0);
      checkOutput("reset_rd_addr", 64'(rd_addr), 64'd0);
      checkOutput("reset_rd_data", 64'(rd_data), 64'd0);
      checkOutput("reset_pending", 64'(pending), 64'd0);
      checkOutput("reset_alu_ready", 64'(alu_ready), 64'd1);
      checkOutput("reset_lsu_ready", 64'(lsu_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single ALU write to x5.
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      expectWrite(5'd5, 32'hDEADBEEF);
      @(negedge clk);
      checkOutput("single_alu_ready", 64'(alu_ready), 64'd1);
      @(posedge clk); #1;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      checkOutput("single_pending_held", 64'(pending), 64'h20);
      checkOutput("single_we_early", 64'(rd_we), 64'd0);
      @(negedge clk);
      checkOutput("single_we", 64'(rd_we), 64'd1);
      checkOutput("single_pending_port", 64'(pending), 64'h20);
      @(negedge clk);
      checkOutput("single_pending_clear", 64'(pending), 64'd0);
      checkOutput("single_we_done", 64'(rd_we), 64'd0);

      // Contention: grant pattern L,L,L,A with the ALU starved for three cycles.
      aluSeq = 0;
      lsuSeq = 0;
      aluTake = 1'b1;
      lsuTake = 1'b1;
      expectWrite(5'd4, 32'h022);
      expectWrite(5'd4, 32'h122);
      expectWrite(5'd4, 32'h222);
      expectWrite(5'd3, 32'h011);
      expectWrite(5'd4, 32'h322);
      expectWrite(5'd4, 32'h422);
      expectWrite(5'd4, 32'h522);
      expectWrite(5'd3, 32'h111);
      expectWrite(5'd4, 32'h622);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b1, 5'd3, 32'(32'h11 + (aluSeq << 8)), 1'b1, 5'd4, 32'(32'h22 + (lsuSeq << 8)));
         @(posedge clk);
         if (aluTake) aluSeq++;
         if (lsuTake) lsuSeq++;
         @(negedge clk);
         checkOutput($sformatf("contend_alu_ready_%0d", k), 64'(alu_ready), 64'(aluRdyExp[k]));
         checkOutput($sformatf("contend_lsu_ready_%0d", k), 64'(lsu_ready), 64'(lsuRdyExp[k]));
         aluTake = aluRdyExp[k];
         lsuTake = lsuRdyExp[k];
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      drainAndCheck(4, "contend_drained");

      // LSU write to x0 is acknowledged and dropped.
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      checkOutput("x0_lsu_ready", 64'(lsu_ready), 64'd1);
      @(posedge clk); #1;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("x0_rd_we_%0d", c), 64'(rd_we), 64'd0);
         checkOutput($sformatf("x0_pending_%0d", c), 64'(pending), 64'd0);
      end

      // Same destination from both sources: LSU first, ALU last.
      applyStimulus(1'b1, 5'd7, 32'hBB, 1'b1, 5'd7, 32'hAA);
      expectWrite(5'd7, 32'hAA);
      expectWrite(5'd7, 32'hBB);
      @(posedge clk); #1;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      checkOutput("samerd_pending", 64'(pending), 64'h80);
      @(negedge clk);
      checkOutput("samerd_we_first", 64'(rd_we), 64'd1);
      @(negedge clk);
      checkOutput("samerd_we_second", 64'(rd_we), 64'd1);
      drainAndCheck(1, "samerd_drained");
      checkOutput("samerd_we_idle", 64'(rd_we), 64'd0);

      // Back-to-back ALU stream with the LSU idle.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 5'(8 + i), 32'(32'h1000 + i), 1'b0, 5'd0, 32'd0);
         expectWrite(5'(8 + i), 32'(32'h1000 + i));
         checkOutput($sformatf("stream_alu_ready_%0d", i), 64'(alu_ready), 64'd1);
         if (i >= 2) checkOutput($sformatf("stream_we_%0d", i), 64'(rd_we), 64'd1);
         @(negedge clk);
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      drainAndCheck(3, "stream_drained");

      // Reset asserted while both slots are full and a write is on the port.
      applyStimulus(1'b1, 5'd10, 32'hA0A0, 1'b1, 5'd11, 32'hB1B1);
      expectWrite(5'd11, 32'hB1B1);
      @(posedge clk); #1;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC2C2);
      @(posedge clk); #1;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      checkOutput("midrst_we_before", 64'(rd_we), 64'd1);
      checkOutput("midrst_pending_before", 64'(pending), 64'h1C00);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_rd_we", 64'(rd_we), 64'd0);
      checkOutput("midrst_rd_addr", 64'(rd_addr), 64'd0);
      checkOutput("midrst_rd_data", 64'(rd_data), 64'd0);
      checkOutput("midrst_pending", 64'(pending), 64'd0);
      checkOutput("midrst_alu_ready", 64'(alu_ready), 64'd1);
      checkOutput("midrst_lsu_ready", 64'(lsu_ready), 64'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("postrst_we_%0d", c), 64'(rd_we), 64'd0);
      end
      applyStimulus(1'b1, 5'd13, 32'hD3D3, 1'b0, 5'd0, 32'd0);
      expectWrite(5'd13, 32'hD3D3);
      @(posedge clk); #1;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      drainAndCheck(3, "postrst_drained");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
